id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between ID and EX in the 5-stage core. It feeds the forwarding unit its source register numbers (`ex_rs`/`ex_rt`) and the EX-stage controls. It detects load-use hazards, stalling PC and IF/ID while inserting a bubble. It also handles branch flush, downstream hold, WB-to-ID register bypass, and a saturating stall counter.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register-number width (= `REGISTER_BITS` from `dev.v`)
- `CNT_W`, 16, stall-counter width

- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in `REG_W`: decoded register numbers
- `id_rs_data`, `id_rt_data` in `DATA_W`: register-file read data
- `id_imm` in `DATA_W`: sign-extended immediate
- `id_alu_op` in 4: ALU opcode
- `id_alu_src`, `id_reg_dst`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg` in 1 each: decode controls
- `wb_reg_write` in 1, `wb_rd` in `REG_W`, `wb_data` in `DATA_W`: WB-stage write port
- `ex_flush` in 1: branch/jump resolved taken in EX
- `ex_hold` in 1: downstream stall; freeze this register
- `ex_valid` out 1, `ex_rs`/`ex_rt`/`ex_rd` out `REG_W`, `ex_rs_data`/`ex_rt_data`/`ex_imm` out `DATA_W`, `ex_alu_op` out 4, `ex_alu_src`/`ex_reg_dst`/`ex_mem_read`/`ex_mem_write`/`ex_reg_write`/`ex_mem_to_reg` out 1: registered EX-stage state
- `hz_stall` out 1: freeze PC and IF/ID (combinational)
- `stall_cnt` out `CNT_W`: bubbles inserted since reset

## Operation
- Load-use: `lu = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- `hz_stall = (lu | ex_hold) & ~ex_flush`.
- Per-edge update priority, highest first:
  1. `ex_flush`: load a bubble.
  2. `ex_hold`: keep all `ex_*` unchanged.
  3. `lu`: load a bubble.
  4. Otherwise: load the ID inputs.
- Bubble: `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` are 0. Register numbers are 0. The remaining fields are don't-care but driven to 0.
- WB bypass on load: if `wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs)`, then `ex_rs_data <= wb_data`, else `id_rs_data`. Same rule for rt.
- Writes to register 0 never bypass. `ex_rs`/`ex_rt` are 0 whenever `ex_valid`=0, so forwarding never matches a bubble.
- `stall_cnt` increments by 1 on every edge where rule 3 applies. It saturates at all-ones and never wraps. Flush and hold do not count.

## Timing
- All `ex_*` outputs register on the rising edge, 1-cycle latency ID→EX.
- Reset (async assert, sync-safe release): every output reg is 0, i.e. bubble state, and `stall_cnt`=0. `hz_stall` therefore reads 0 out of reset.
- Reset mid-stall: a pending bubble and the count are lost. The pipeline restarts from the bubble state.
- A load-use stall lasts exactly 1 cycle when `ex_hold`=0, because the bubble clears `ex_mem_read`.
- Under `ex_hold`, `lu` is re-evaluated each cycle on frozen state. No bubble is inserted while held.
- `ex_flush` together with `lu` or `ex_hold`: the flush wins, a bubble loads, `hz_stall`=0, and the count is unchanged.
- Back-to-back loads with dependent consumers: one bubble per dependent pair.

## Structure
- Shared package/`dev.v`: `REGISTER_BITS`, `ALU_OP_W`=4, and the bubble control constant.
- One sub-module, `load_use_detect`, holds the purely combinational `lu` equation. Registers, priority mux, bypass and counter stay in `id_ex_stage`.

## Test plan
- No hazard: ID `rs`=3, `rt`=4, `reg_write`=1, data `0x11`/`0x22` → the next cycle has `ex_rs`=3, `ex_rs_data`=`0x11`, `ex_valid`=1, `hz_stall`=0.
- Load-use: EX holds `lw` with `rt`=5, ID `add` with `rs`=5 → `hz_stall`=1 for 1 cycle. The next EX is a bubble, the `add` loads the cycle after, and `stall_cnt`=1.
- Register-0 guard: EX `lw` `rt`=0, ID `rs`=0 → `hz_stall`=0, no bubble.
- WB bypass: `wb_reg_write`=1, `wb_rd`=7, `wb_data`=`0xDEAD`, ID `rt`=7, `id_rt_data`=`0x0` → `ex_rt_data`=`0xDEAD`. The same setup with `wb_rd`=0 leaves `ex_rt_data`=`0x0`.
- Flush vs stall: `lu`=1 and `ex_flush`=1 in the same cycle → `hz_stall`=0, bubble loaded, `stall_cnt` unchanged. A 3-cycle `ex_hold` → `ex_*` frozen and `hz_stall`=1 for all 3 cycles.
- Reset and saturation: assert `rst_n`=0 mid-stall → outputs 0 immediately. With `CNT_W`=2, five load-use stalls → `stall_cnt`=3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: register-number width,
// ALU opcode width, the packed EX control bundle and its bubble value.
package id_ex_stage_pkg;

    localparam int REGISTER_BITS = 5;
    localparam int ALU_OP_W      = 4;
    localparam int CTRL_W        = ALU_OP_W + 6;

    // EX-stage control bundle carried through the pipeline register.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_dst;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
    } ex_ctrl_t;

    // A bubble carries no side effects: every control bit is cleared.
    localparam ex_ctrl_t BUBBLE_CTRL = ex_ctrl_t'({CTRL_W{1'b0}});

    // What the pipeline register loads on the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_BUBBLE = 2'd1,
        SEL_ID     = 2'd2
    } ex_sel_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination (rt) is a non-zero register read by the instruction in ID.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             lu
);

    logic rt_nonzero_s;
    logic rt_match_s;

    assign rt_nonzero_s = (ex_rt != {REG_W{1'b0}});
    assign rt_match_s   = (ex_rt == id_rs) | (ex_rt == id_rt);
    assign lu           = id_valid & ex_valid & ex_mem_read & rt_nonzero_s & rt_match_s;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, downstream hold,
// WB-to-ID register bypass and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = REGISTER_BITS,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [DATA_W-1:0]   id_rs_data,
    input  logic [DATA_W-1:0]   id_rt_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,
    input  logic                wb_reg_write,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                ex_flush,
    input  logic                ex_hold,
    output logic                ex_valid,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_rd,
    output logic [DATA_W-1:0]   ex_rs_data,
    output logic [DATA_W-1:0]   ex_rt_data,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_reg_dst,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic                hz_stall,
    output logic [CNT_W-1:0]    stall_cnt
);

    // Pipeline state
    logic              ex_valid_r;
    logic [REG_W-1:0]  ex_rs_r;
    logic [REG_W-1:0]  ex_rt_r;
    logic [REG_W-1:0]  ex_rd_r;
    logic [DATA_W-1:0] ex_rs_data_r;
    logic [DATA_W-1:0] ex_rt_data_r;
    logic [DATA_W-1:0] ex_imm_r;
    ex_ctrl_t          ex_ctrl_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Next-state values
    logic              valid_nxt_s;
    logic [REG_W-1:0]  rs_nxt_s;
    logic [REG_W-1:0]  rt_nxt_s;
    logic [REG_W-1:0]  rd_nxt_s;
    logic [DATA_W-1:0] rs_data_nxt_s;
    logic [DATA_W-1:0] rt_data_nxt_s;
    logic [DATA_W-1:0] imm_nxt_s;
    ex_ctrl_t          ctrl_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;

    logic              lu_s;
    ex_sel_t           sel_s;
    logic              cnt_inc_s;
    logic [DATA_W-1:0] rs_byp_s;
    logic [DATA_W-1:0] rt_byp_s;
    ex_ctrl_t          id_ctrl_s;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid_r),
        .ex_mem_read (ex_ctrl_r.mem_read),
        .ex_rt       (ex_rt_r),
        .lu          (lu_s)
    );

    // A taken branch squashes the stall request: the stalled instruction is
    // on the wrong path and the front end must be free to redirect.
    assign hz_stall = (lu_s | ex_hold) & ~ex_flush;

    assign id_ctrl_s = '{
        alu_op:     id_alu_op,
        alu_src:    id_alu_src,
        reg_dst:    id_reg_dst,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        reg_write:  id_reg_write,
        mem_to_reg: id_mem_to_reg
    };

    // Choose what loads next: flush beats hold beats load-use beats ID.
    always_comb begin
        sel_s     = SEL_BUBBLE;
        cnt_inc_s = 1'b0;
        if (ex_flush) begin
            sel_s = SEL_BUBBLE;
        end else if (ex_hold) begin
            sel_s = SEL_HOLD;
        end else if (lu_s) begin
            sel_s     = SEL_BUBBLE;
            cnt_inc_s = 1'b1;
        end else if (id_valid) begin
            sel_s = SEL_ID;
        end else begin
            // An empty ID slot enters EX as a bubble so ex_rs/ex_rt stay 0.
            sel_s = SEL_BUBBLE;
        end
    end

    // WB writes in the same cycle as the ID read; take the fresh value,
    // except for register 0 which is hard-wired and never written.
    always_comb begin
        rs_byp_s = id_rs_data;
        rt_byp_s = id_rt_data;
        if (wb_reg_write && (wb_rd != {REG_W{1'b0}}) && (wb_rd == id_rs)) begin
            rs_byp_s = wb_data;
        end else begin
            rs_byp_s = id_rs_data;
        end
        if (wb_reg_write && (wb_rd != {REG_W{1'b0}}) && (wb_rd == id_rt)) begin
            rt_byp_s = wb_data;
        end else begin
            rt_byp_s = id_rt_data;
        end
    end

    // Build the next pipeline-register contents from the selection.
    always_comb begin
        valid_nxt_s   = 1'b0;
        rs_nxt_s      = {REG_W{1'b0}};
        rt_nxt_s      = {REG_W{1'b0}};
        rd_nxt_s      = {REG_W{1'b0}};
        rs_data_nxt_s = {DATA_W{1'b0}};
        rt_data_nxt_s = {DATA_W{1'b0}};
        imm_nxt_s     = {DATA_W{1'b0}};
        ctrl_nxt_s    = BUBBLE_CTRL;
        case (sel_s)
            SEL_HOLD: begin
                valid_nxt_s   = ex_valid_r;
                rs_nxt_s      = ex_rs_r;
                rt_nxt_s      = ex_rt_r;
                rd_nxt_s      = ex_rd_r;
                rs_data_nxt_s = ex_rs_data_r;
                rt_data_nxt_s = ex_rt_data_r;
                imm_nxt_s     = ex_imm_r;
                ctrl_nxt_s    = ex_ctrl_r;
            end
            SEL_ID: begin
                valid_nxt_s   = 1'b1;
                rs_nxt_s      = id_rs;
                rt_nxt_s      = id_rt;
                rd_nxt_s      = id_rd;
                rs_data_nxt_s = rs_byp_s;
                rt_data_nxt_s = rt_byp_s;
                imm_nxt_s     = id_imm;
                ctrl_nxt_s    = id_ctrl_s;
            end
            SEL_BUBBLE: begin
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = BUBBLE_CTRL;
            end
            default: begin
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = BUBBLE_CTRL;
            end
        endcase
    end

    // Bubble counter sticks at all-ones rather than wrapping to zero.
    always_comb begin
        cnt_nxt_s = stall_cnt_r;
        if (cnt_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = stall_cnt_r;
        end
    end

    // Pipeline register and counter; reset leaves a bubble in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r   <= 1'b0;
            ex_rs_r      <= {REG_W{1'b0}};
            ex_rt_r      <= {REG_W{1'b0}};
            ex_rd_r      <= {REG_W{1'b0}};
            ex_rs_data_r <= {DATA_W{1'b0}};
            ex_rt_data_r <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
            ex_ctrl_r    <= BUBBLE_CTRL;
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            ex_valid_r   <= valid_nxt_s;
            ex_rs_r      <= rs_nxt_s;
            ex_rt_r      <= rt_nxt_s;
            ex_rd_r      <= rd_nxt_s;
            ex_rs_data_r <= rs_data_nxt_s;
            ex_rt_data_r <= rt_data_nxt_s;
            ex_imm_r     <= imm_nxt_s;
            ex_ctrl_r    <= ctrl_nxt_s;
            stall_cnt_r  <= cnt_nxt_s;
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_rs         = ex_rs_r;
    assign ex_rt         = ex_rt_r;
    assign ex_rd         = ex_rd_r;
    assign ex_rs_data    = ex_rs_data_r;
    assign ex_rt_data    = ex_rt_data_r;
    assign ex_imm        = ex_imm_r;
    assign ex_alu_op     = ex_ctrl_r.alu_op;
    assign ex_alu_src    = ex_ctrl_r.alu_src;
    assign ex_reg_dst    = ex_ctrl_r.reg_dst;
    assign ex_mem_read   = ex_ctrl_r.mem_read;
    assign ex_mem_write  = ex_ctrl_r.mem_write;
    assign ex_reg_write  = ex_ctrl_r.reg_write;
    assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
    assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a behavioural model
// of the EX-stage contents; a second instance with a 2-bit counter covers
// saturation.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush, ex_hold;

    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic        hz_stall;
    logic [15:0] stall_cnt;

    logic        s_valid;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_rs_data, s_rt_data, s_imm;
    logic [3:0]  s_alu_op;
    logic        s_alu_src, s_reg_dst, s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg;
    logic        s_hz_stall;
    logic [1:0]  s_stall_cnt;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .hz_stall(hz_stall), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .ex_hold(ex_hold),
        .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
        .ex_alu_op(s_alu_op), .ex_alu_src(s_alu_src), .ex_reg_dst(s_reg_dst),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
        .ex_reg_write(s_reg_write), .ex_mem_to_reg(s_mem_to_reg),
        .hz_stall(s_hz_stall), .stall_cnt(s_stall_cnt)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of what EX should hold: one instruction or nothing.
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rs_data, rt_data, imm;
        bit [3:0]  alu_op;
        bit        alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg;
    } ex_model_t;

    ex_model_t   m;
    int unsigned m_bubbles;
    int          err_cnt;
    int          chk_cnt;

    // Compare one observed value with the expected one and tally the result.
    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m = '{default: 0};
    endtask

    // Every EX output of both instances against the model.
    task automatic compare_all();
        check_val("ex_valid",      ex_valid,      m.valid);
        check_val("ex_rs",         ex_rs,         m.rs);
        check_val("ex_rt",         ex_rt,         m.rt);
        check_val("ex_rd",         ex_rd,         m.rd);
        check_val("ex_rs_data",    ex_rs_data,    m.rs_data);
        check_val("ex_rt_data",    ex_rt_data,    m.rt_data);
        check_val("ex_imm",        ex_imm,        m.imm);
        check_val("ex_alu_op",     ex_alu_op,     m.alu_op);
        check_val("ex_ctrl",
                  {ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
                  {m.alu_src, m.reg_dst, m.mem_read, m.mem_write, m.reg_write, m.mem_to_reg});
        check_val("stall_cnt",     stall_cnt,     (m_bubbles > 65535) ? 65535 : m_bubbles);
        check_val("stall_cnt_sat", s_stall_cnt,   (m_bubbles > 3) ? 3 : m_bubbles);
        check_val("sat_ex_valid",  s_valid,       m.valid);
    endtask

    // One clock: check the stall decision, advance the model, check EX.
    task automatic tick();
        bit        lu;
        bit        hz;
        ex_model_t n;
        #1;
        lu = id_valid && m.valid && m.mem_read && (m.rt != 5'd0) &&
             ((m.rt == id_rs) || (m.rt == id_rt));
        hz = (lu || ex_hold) && !ex_flush;
        check_val("hz_stall", hz_stall, hz);
        n = '{default: 0};
        if (ex_flush) begin
            n = '{default: 0};
        end else if (ex_hold) begin
            n = m;
        end else if (lu) begin
            n = '{default: 0};
            m_bubbles++;
        end else if (id_valid) begin
            n.valid      = 1'b1;
            n.rs         = id_rs;
            n.rt         = id_rt;
            n.rd         = id_rd;
            n.rs_data    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_data : id_rs_data;
            n.rt_data    = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_data : id_rt_data;
            n.imm        = id_imm;
            n.alu_op     = id_alu_op;
            n.alu_src    = id_alu_src;
            n.reg_dst    = id_reg_dst;
            n.mem_read   = id_mem_read;
            n.mem_write  = id_mem_write;
            n.reg_write  = id_reg_write;
            n.mem_to_reg = id_mem_to_reg;
        end
        @(posedge clk);
        m = n;
        #1;
        compare_all();
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                          input bit [4:0] rd, input bit mr, input bit rw,
                          input bit [31:0] rsd, input bit [31:0] rtd);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_rd         = rd;
        id_mem_read   = mr;
        id_reg_write  = rw;
        id_mem_write  = 1'b0;
        id_mem_to_reg = mr;
        id_alu_src    = mr;
        id_reg_dst    = ~mr;
        id_alu_op     = 4'h2;
        id_imm        = 32'h0000_0010;
        id_rs_data    = rsd;
        id_rt_data    = rtd;
    endtask

    task automatic quiet_ctrl();
        wb_reg_write = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'h0;
        ex_flush     = 1'b0;
        ex_hold      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        m_bubbles = 0;
        compare_all();
        check_val("rst_hz_stall", hz_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        m_bubbles = 0;
        model_clear();
        rst_n = 1'b0;
        quiet_ctrl();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        do_reset();

        // No hazard: plain ALU instruction flows into EX.
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b0, 1'b1, 32'h11, 32'h22);
        tick();
        check_val("nohz_rs", ex_rs, 5'd3);
        check_val("nohz_rs_data", ex_rs_data, 32'h11);
        check_val("nohz_valid", ex_valid, 1'b1);

        // Load-use: lw rt=5 then add rs=5.
        set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 32'h100, 32'h0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h33, 32'h44);
        #1;
        check_val("lu_hz", hz_stall, 1'b1);
        tick();
        check_val("lu_bubble", ex_valid, 1'b0);
        check_val("lu_hz_clear", hz_stall, 1'b0);
        tick();
        check_val("lu_add_rs", ex_rs, 5'd5);
        check_val("lu_cnt", stall_cnt, 16'd1);

        // Register-0 guard: lw rt=0 followed by a reader of r0.
        set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        check_val("r0_hz", hz_stall, 1'b0);
        tick();
        check_val("r0_no_bubble", ex_valid, 1'b1);

        // WB bypass, then the same with a write to r0.
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        set_id(1'b1, 5'd1, 5'd7, 5'd2, 1'b0, 1'b1, 32'h55, 32'h0);
        tick();
        check_val("byp_rt", ex_rt_data, 32'hDEAD);
        wb_rd = 5'd0;
        tick();
        check_val("byp_r0_rt", ex_rt_data, 32'h0);
        quiet_ctrl();

        // Flush wins over a pending load-use stall.
        set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h1, 32'h2);
        ex_flush = 1'b1;
        #1;
        check_val("flush_hz", hz_stall, 1'b0);
        tick();
        check_val("flush_bubble", ex_valid, 1'b0);
        check_val("flush_cnt", stall_cnt, 16'd1);
        ex_flush = 1'b0;

        // Three-cycle hold freezes EX and keeps the front end stalled.
        set_id(1'b1, 5'd10, 5'd11, 5'd12, 1'b0, 1'b1, 32'hAAAA, 32'hBBBB);
        tick();
        set_id(1'b1, 5'd13, 5'd14, 5'd15, 1'b0, 1'b1, 32'h1, 32'h2);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("hold_hz", hz_stall, 1'b1);
            tick();
            check_val("hold_rs", ex_rs, 5'd10);
        end
        ex_hold = 1'b0;
        tick();

        // Reset in the middle of a stall drops the bubble and the count.
        set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h1, 32'h2);
        #1;
        check_val("pre_rst_hz", hz_stall, 1'b1);
        do_reset();
        check_val("rst_cnt", stall_cnt, 16'd0);

        // Five load-use stalls saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0);
            tick();
            set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 32'h1, 32'h2);
            tick();
            tick();
        end
        check_val("sat_cnt", s_stall_cnt, 2'd3);
        check_val("full_cnt", stall_cnt, 16'd5);

        // Randomised traffic over a small register set to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            id_valid      = ($urandom_range(0, 7) != 0);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 31));
            id_rs_data    = $urandom;
            id_rt_data    = $urandom;
            id_imm        = $urandom;
            id_alu_op     = 4'($urandom_range(0, 15));
            id_alu_src    = 1'($urandom_range(0, 1));
            id_reg_dst    = 1'($urandom_range(0, 1));
            id_mem_read   = 1'($urandom_range(0, 1));
            id_mem_write  = 1'($urandom_range(0, 1));
            id_reg_write  = 1'($urandom_range(0, 1));
            id_mem_to_reg = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_rd         = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            ex_flush      = ($urandom_range(0, 7) == 0);
            ex_hold       = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
